// File: rtl/pp_term_accumulator.sv
// pp_term_accumulator: sums NUM_PP signed encoder terms, term k weighted by 2^(k*SHIFT),
// and holds the result until the consumer takes it.
module pp_term_accumulator #(
  parameter int LOG_WIDTH = 6,
  parameter int NUM_PP = 8,
  parameter int SHIFT = 2,
  localparam int ACC_W = LOG_WIDTH + 1 + (NUM_PP - 1) * SHIFT + $clog2(NUM_PP),
  localparam int CNT_W = $clog2(NUM_PP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [LOG_WIDTH:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] term_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, ext, term;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last;
  assign ext = {{(ACC_W-LOG_WIDTH-1){in_data[LOG_WIDTH]}}, in_data};
  assign term = ext << (int'(cnt_q) * SHIFT);
  assign last = cnt_q == CNT_W'(NUM_PP - 1);
  assign in_ready = (state_q != DONE) && !clear;
  assign sum = sum_q;
  assign sum_valid = state_q == DONE;
  assign term_count = cnt_q;
  // IDLE always holds acc=0 and cnt=0, so it shares the ACCUM accept path
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (clear) begin
      state_d = IDLE;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == DONE) begin
      state_d = sum_ready ? IDLE : DONE;
    end else if (in_valid) begin
      acc_d = last ? '0 : acc_q + term;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      sum_d = last ? acc_q + term : sum_q;
      state_d = last ? DONE : ACCUM;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pp_term_accumulator.sv
// tb_pp_term_accumulator: directed scenarios plus random packets checked against an arithmetic model
module tb_pp_term_accumulator;
  localparam int NPP = 8;
  localparam int SH = 2;
  logic clk, rst, clear, in_valid, in_ready, sum_valid, sum_ready;
  logic [6:0] in_data;
  logic [23:0] sum;
  logic [2:0] term_count;
  logic [6:0] terms [NPP];
  logic [23:0] held;
  int checks = 0;
  int failures = 0;

  pp_term_accumulator dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .term_count(term_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_sum();
    longint s = 0;
    for (int k = 0; k < NPP; k++) s += longint'($signed(terms[k])) * (longint'(1) << (k * SH));
    return s[23:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input int maxgap, input string tag);
    repeat ($urandom_range(maxgap, 0)) begin
      in_valid = 1'b0;
      in_data = 7'($urandom);
      tick();
      chk({tag, "_gap_cnt"}, 32'(term_count), 32'(k));
    end
    in_valid = 1'b1;
    in_data = terms[k];
    tick();
    in_valid = 1'b0;
    chk({tag, "_cnt"}, 32'(term_count), 32'((k + 1) % NPP));
    chk({tag, "_sv"}, 32'(sum_valid), 32'(k == NPP - 1));
  endtask

  task automatic run_packet(input int maxgap, input string tag);
    for (int k = 0; k < NPP; k++) send(k, maxgap, tag);
    chk({tag, "_sum"}, 32'(sum), 32'(ref_sum()));
  endtask

  task automatic handshake(input string tag);
    held = sum;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk({tag, "_hs_sv"}, 32'(sum_valid), 0);
    chk({tag, "_hs_rdy"}, 32'(in_ready), 1);
    chk({tag, "_hs_sum"}, 32'(sum), 32'(held));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; sum_ready = 1'b0;
    #1;
    chk("rst_sum", 32'(sum), 0);
    chk("rst_sv", 32'(sum_valid), 0);
    chk("rst_cnt", 32'(term_count), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    #2 rst = 1'b0;
    tick();

    for (int k = 0; k < NPP; k++) terms[k] = 7'h01;
    run_packet(0, "ones");
    chk("ones_const", 32'(sum), 32'h005555);
    handshake("ones");

    for (int k = 0; k < NPP; k++) terms[k] = 7'h40;
    run_packet(3, "neg64");
    chk("neg64_const", 32'(sum), 32'hEAAAC0);
    held = sum;
    in_valid = 1'b1;
    in_data = 7'h01;
    repeat (5) begin
      tick();
      chk("bp_sum", 32'(sum), 32'(held));
      chk("bp_rdy", 32'(in_ready), 0);
      chk("bp_cnt", 32'(term_count), 0);
      chk("bp_sv", 32'(sum_valid), 1);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_idle_sv", 32'(sum_valid), 0);
    chk("bp_noacc_cnt", 32'(term_count), 0);
    chk("bp_sum_kept", 32'(sum), 32'(held));

    for (int k = 0; k < NPP; k++) terms[k] = 7'($urandom);
    for (int k = 0; k < 3; k++) send(k, 1, "clr_pre");
    in_valid = 1'b1;
    in_data = 7'h11;
    clear = 1'b1;
    #1;
    chk("clr_rdy", 32'(in_ready), 0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt", 32'(term_count), 0);
    chk("clr_sv", 32'(sum_valid), 0);
    for (int k = 0; k < NPP; k++) terms[k] = (k == 0) ? 7'd5 : 7'd0;
    run_packet(2, "clr_post");
    chk("clr_const", 32'(sum), 32'h000005);

    clear = 1'b1;
    sum_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    clear = 1'b0;
    sum_ready = 1'b0;
    in_valid = 1'b0;
    chk("clr_done_sv", 32'(sum_valid), 0);
    chk("clr_done_cnt", 32'(term_count), 0);

    for (int k = 0; k < NPP; k++) terms[k] = 7'($urandom);
    for (int k = 0; k < 4; k++) send(k, 1, "mid_pre");
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(sum), 0);
    chk("mid_rst_sv", 32'(sum_valid), 0);
    chk("mid_rst_cnt", 32'(term_count), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
    #2 rst = 1'b0;
    tick();
    for (int k = 0; k < NPP; k++) terms[k] = 7'h3F;
    run_packet(1, "p63");
    chk("p63_const", 32'(sum), 32'h14FFEB);
    handshake("p63");

    for (int p = 0; p < 30; p++) begin
      for (int k = 0; k < NPP; k++) terms[k] = 7'($urandom);
      run_packet(3, "rnd");
      held = sum;
      repeat ($urandom_range(3, 0)) begin
        in_valid = 1'($urandom);
        tick();
        chk("rnd_hold_sum", 32'(sum), 32'(held));
        chk("rnd_hold_sv", 32'(sum_valid), 1);
      end
      in_valid = 1'b0;
      handshake("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
